// File: rtl/axi_reg_slice_pkg.sv
// Shared types and widths for the AXI4 register slice.
// Holds the packed payload structs for each channel (aw_t, ar_t, w_t, b_t, r_t),
// the field widths they are built from, and named burst/response encodings.
// No ports; imported by axi_skid_buffer users and the axi_reg_slice top.

package axi_reg_slice_pkg;

    localparam int ADDR_W  = 20;
    localparam int DATA_W  = 32;
    localparam int ID_W    = 8;
    localparam int STRB_W  = DATA_W / 8;
    localparam int LEN_W   = 8;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;
    localparam int CACHE_W = 4;
    localparam int PROT_W  = 3;
    localparam int RESP_W  = 2;

    typedef enum logic [BURST_W-1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    typedef enum logic [RESP_W-1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    // Burst and response fields are plain vectors rather than the enums above so
    // that every encoding, including the reserved burst value, passes through
    // bit-exact.
    typedef struct packed {
        logic [ID_W-1:0]    id;
        logic [ADDR_W-1:0]  addr;
        logic [LEN_W-1:0]   len;
        logic [SIZE_W-1:0]  size;
        logic [BURST_W-1:0] burst;
        logic               lock;
        logic [CACHE_W-1:0] cache;
        logic [PROT_W-1:0]  prot;
    } aw_t;

    typedef struct packed {
        logic [ID_W-1:0]    id;
        logic [ADDR_W-1:0]  addr;
        logic [LEN_W-1:0]   len;
        logic [SIZE_W-1:0]  size;
        logic [BURST_W-1:0] burst;
        logic               lock;
        logic [CACHE_W-1:0] cache;
        logic [PROT_W-1:0]  prot;
    } ar_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
        logic              last;
    } w_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [RESP_W-1:0] resp;
    } b_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [RESP_W-1:0] resp;
        logic              last;
    } r_t;

endpackage

// File: rtl/axi_skid_buffer.sv
// Generic two-entry skid stage for one valid/ready channel.
// Ports:
//   clk, areset_n        clock, synchronous active-low reset
//   in_valid/in_ready    upstream handshake; in_ready is a flop output
//   in_data              upstream payload of type T
//   out_valid/out_ready  downstream handshake; out_valid is a flop output
//   out_data             downstream payload, driven straight from a register
// Handshake: a beat transfers on any rising clk where valid && ready. Once a
// stage raises out_valid it holds out_valid and out_data until out_ready is seen.

module axi_skid_buffer #(
    parameter type T = logic
) (
    input  logic clk,
    input  logic areset_n,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    logic out_valid_q, out_valid_d;
    logic skid_valid_q, skid_valid_d;
    logic in_ready_q, in_ready_d;
    T     out_data_q, out_data_d;
    T     skid_data_q, skid_data_d;

    logic accept;
    logic drain;

    assign accept = in_valid && in_ready_q;
    assign drain  = out_valid_q && out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (skid_valid_q) begin
            // in_ready is low while skid is full, so only a drain can happen.
            if (drain) begin
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!out_valid_q || drain) begin
                // Main is empty or emptying this cycle: reload it, no bubble.
                out_valid_d = 1'b1;
                out_data_d  = in_data;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
            end
        end else if (drain) begin
            out_valid_d = 1'b0;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (!areset_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    // Payload registers carry no reset; they are only observed under a valid.
    always_ff @(posedge clk) begin
        out_data_q  <= out_data_d;
        skid_data_q <= skid_data_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: rtl/axi_reg_slice.sv
// Full AXI4 register slice: one skid stage on each of AW, W, AR (manager to
// subordinate) and B, R (subordinate to manager). Every output is a flop, one
// cycle of forward latency, one beat per cycle per channel sustained.
// Ports:
//   clk, areset_n      single clock, synchronous active-low reset
//   s_aw*/s_w*/s_ar*   manager-side request channels (payload/valid in, ready out)
//   s_b*/s_r*          manager-side response channels (payload/valid out, ready in)
//   m_aw*/m_w*/m_ar*   subordinate-side request channels (payload/valid out, ready in)
//   m_b*/m_r*          subordinate-side response channels (payload/valid in, ready out)

module axi_reg_slice
    import axi_reg_slice_pkg::*;
#(
    parameter  int AddrWidth = ADDR_W,
    parameter  int DataWidth = DATA_W,
    parameter  int IdWidth   = ID_W,
    localparam int StrbWidth = DataWidth / 8
) (
    input  logic                 clk,
    input  logic                 areset_n,
    // manager-side AW
    input  logic [IdWidth-1:0]   s_awid_i,
    input  logic [AddrWidth-1:0] s_awaddr_i,
    input  logic [7:0]           s_awlen_i,
    input  logic [2:0]           s_awsize_i,
    input  logic [1:0]           s_awburst_i,
    input  logic                 s_awlock_i,
    input  logic [3:0]           s_awcache_i,
    input  logic [2:0]           s_awprot_i,
    input  logic                 s_awvalid_i,
    output logic                 s_awready_o,
    // manager-side W
    input  logic [DataWidth-1:0] s_wdata_i,
    input  logic [StrbWidth-1:0] s_wstrb_i,
    input  logic                 s_wlast_i,
    input  logic                 s_wvalid_i,
    output logic                 s_wready_o,
    // manager-side B
    output logic [IdWidth-1:0]   s_bid_o,
    output logic [1:0]           s_bresp_o,
    output logic                 s_bvalid_o,
    input  logic                 s_bready_i,
    // manager-side AR
    input  logic [IdWidth-1:0]   s_arid_i,
    input  logic [AddrWidth-1:0] s_araddr_i,
    input  logic [7:0]           s_arlen_i,
    input  logic [2:0]           s_arsize_i,
    input  logic [1:0]           s_arburst_i,
    input  logic                 s_arlock_i,
    input  logic [3:0]           s_arcache_i,
    input  logic [2:0]           s_arprot_i,
    input  logic                 s_arvalid_i,
    output logic                 s_arready_o,
    // manager-side R
    output logic [IdWidth-1:0]   s_rid_o,
    output logic [DataWidth-1:0] s_rdata_o,
    output logic [1:0]           s_rresp_o,
    output logic                 s_rlast_o,
    output logic                 s_rvalid_o,
    input  logic                 s_rready_i,
    // subordinate-side AW
    output logic [IdWidth-1:0]   m_awid_o,
    output logic [AddrWidth-1:0] m_awaddr_o,
    output logic [7:0]           m_awlen_o,
    output logic [2:0]           m_awsize_o,
    output logic [1:0]           m_awburst_o,
    output logic                 m_awlock_o,
    output logic [3:0]           m_awcache_o,
    output logic [2:0]           m_awprot_o,
    output logic                 m_awvalid_o,
    input  logic                 m_awready_i,
    // subordinate-side W
    output logic [DataWidth-1:0] m_wdata_o,
    output logic [StrbWidth-1:0] m_wstrb_o,
    output logic                 m_wlast_o,
    output logic                 m_wvalid_o,
    input  logic                 m_wready_i,
    // subordinate-side B
    input  logic [IdWidth-1:0]   m_bid_i,
    input  logic [1:0]           m_bresp_i,
    input  logic                 m_bvalid_i,
    output logic                 m_bready_o,
    // subordinate-side AR
    output logic [IdWidth-1:0]   m_arid_o,
    output logic [AddrWidth-1:0] m_araddr_o,
    output logic [7:0]           m_arlen_o,
    output logic [2:0]           m_arsize_o,
    output logic [1:0]           m_arburst_o,
    output logic                 m_arlock_o,
    output logic [3:0]           m_arcache_o,
    output logic [2:0]           m_arprot_o,
    output logic                 m_arvalid_o,
    input  logic                 m_arready_i,
    // subordinate-side R
    input  logic [IdWidth-1:0]   m_rid_i,
    input  logic [DataWidth-1:0] m_rdata_i,
    input  logic [1:0]           m_rresp_i,
    input  logic                 m_rlast_i,
    input  logic                 m_rvalid_i,
    output logic                 m_rready_o
);

    aw_t aw_in, aw_out;
    w_t  w_in,  w_out;
    b_t  b_in,  b_out;
    ar_t ar_in, ar_out;
    r_t  r_in,  r_out;

    // Port bundles map onto the package structs field-for-field, in struct order.
    assign aw_in = {s_awid_i, s_awaddr_i, s_awlen_i, s_awsize_i, s_awburst_i,
                    s_awlock_i, s_awcache_i, s_awprot_i};
    assign {m_awid_o, m_awaddr_o, m_awlen_o, m_awsize_o, m_awburst_o,
            m_awlock_o, m_awcache_o, m_awprot_o} = aw_out;

    assign w_in = {s_wdata_i, s_wstrb_i, s_wlast_i};
    assign {m_wdata_o, m_wstrb_o, m_wlast_o} = w_out;

    assign b_in = {m_bid_i, m_bresp_i};
    assign {s_bid_o, s_bresp_o} = b_out;

    assign ar_in = {s_arid_i, s_araddr_i, s_arlen_i, s_arsize_i, s_arburst_i,
                    s_arlock_i, s_arcache_i, s_arprot_i};
    assign {m_arid_o, m_araddr_o, m_arlen_o, m_arsize_o, m_arburst_o,
            m_arlock_o, m_arcache_o, m_arprot_o} = ar_out;

    assign r_in = {m_rid_i, m_rdata_i, m_rresp_i, m_rlast_i};
    assign {s_rid_o, s_rdata_o, s_rresp_o, s_rlast_o} = r_out;

    axi_skid_buffer #(.T(aw_t)) u_aw (
        .clk       (clk),
        .areset_n  (areset_n),
        .in_valid  (s_awvalid_i),
        .in_ready  (s_awready_o),
        .in_data   (aw_in),
        .out_valid (m_awvalid_o),
        .out_ready (m_awready_i),
        .out_data  (aw_out)
    );

    axi_skid_buffer #(.T(w_t)) u_w (
        .clk       (clk),
        .areset_n  (areset_n),
        .in_valid  (s_wvalid_i),
        .in_ready  (s_wready_o),
        .in_data   (w_in),
        .out_valid (m_wvalid_o),
        .out_ready (m_wready_i),
        .out_data  (w_out)
    );

    // Response stages run subordinate -> manager.
    axi_skid_buffer #(.T(b_t)) u_b (
        .clk       (clk),
        .areset_n  (areset_n),
        .in_valid  (m_bvalid_i),
        .in_ready  (m_bready_o),
        .in_data   (b_in),
        .out_valid (s_bvalid_o),
        .out_ready (s_bready_i),
        .out_data  (b_out)
    );

    axi_skid_buffer #(.T(ar_t)) u_ar (
        .clk       (clk),
        .areset_n  (areset_n),
        .in_valid  (s_arvalid_i),
        .in_ready  (s_arready_o),
        .in_data   (ar_in),
        .out_valid (m_arvalid_o),
        .out_ready (m_arready_i),
        .out_data  (ar_out)
    );

    axi_skid_buffer #(.T(r_t)) u_r (
        .clk       (clk),
        .areset_n  (areset_n),
        .in_valid  (m_rvalid_i),
        .in_ready  (m_rready_o),
        .in_data   (r_in),
        .out_valid (s_rvalid_o),
        .out_ready (s_rready_i),
        .out_data  (r_out)
    );

endmodule

// File: tb/tb_axi_reg_slice.sv
// Randomized bench for axi_reg_slice. Each of the five channels is treated as a
// generic valid/ready pipe: channel 0 AW, 1 W, 2 AR, 3 B, 4 R. The reference
// model sees each channel as an in-order store of at most two beats: in_ready is
// high whenever fewer than two beats are held (except the first cycle after
// reset), out_valid is high whenever at least one beat is held, and out_data is
// the oldest held beat.

module tb_axi_reg_slice;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic areset_n;

    // DUT port signals
    logic [7:0]  s_awid_i;   logic [19:0] s_awaddr_i; logic [7:0] s_awlen_i;
    logic [2:0]  s_awsize_i; logic [1:0]  s_awburst_i; logic s_awlock_i;
    logic [3:0]  s_awcache_i; logic [2:0] s_awprot_i; logic s_awvalid_i; logic s_awready_o;
    logic [31:0] s_wdata_i;  logic [3:0]  s_wstrb_i;  logic s_wlast_i;
    logic        s_wvalid_i; logic        s_wready_o;
    logic [7:0]  s_bid_o;    logic [1:0]  s_bresp_o;  logic s_bvalid_o; logic s_bready_i;
    logic [7:0]  s_arid_i;   logic [19:0] s_araddr_i; logic [7:0] s_arlen_i;
    logic [2:0]  s_arsize_i; logic [1:0]  s_arburst_i; logic s_arlock_i;
    logic [3:0]  s_arcache_i; logic [2:0] s_arprot_i; logic s_arvalid_i; logic s_arready_o;
    logic [7:0]  s_rid_o;    logic [31:0] s_rdata_o;  logic [1:0] s_rresp_o;
    logic        s_rlast_o;  logic        s_rvalid_o; logic s_rready_i;
    logic [7:0]  m_awid_o;   logic [19:0] m_awaddr_o; logic [7:0] m_awlen_o;
    logic [2:0]  m_awsize_o; logic [1:0]  m_awburst_o; logic m_awlock_o;
    logic [3:0]  m_awcache_o; logic [2:0] m_awprot_o; logic m_awvalid_o; logic m_awready_i;
    logic [31:0] m_wdata_o;  logic [3:0]  m_wstrb_o;  logic m_wlast_o;
    logic        m_wvalid_o; logic        m_wready_i;
    logic [7:0]  m_bid_i;    logic [1:0]  m_bresp_i;  logic m_bvalid_i; logic m_bready_o;
    logic [7:0]  m_arid_o;   logic [19:0] m_araddr_o; logic [7:0] m_arlen_o;
    logic [2:0]  m_arsize_o; logic [1:0]  m_arburst_o; logic m_arlock_o;
    logic [3:0]  m_arcache_o; logic [2:0] m_arprot_o; logic m_arvalid_o; logic m_arready_i;
    logic [7:0]  m_rid_i;    logic [31:0] m_rdata_i;  logic [1:0] m_rresp_i;
    logic        m_rlast_i;  logic        m_rvalid_i; logic m_rready_o;

    // generic per-channel view
    logic [4:0]  in_v, out_r, in_r, out_v;
    logic [63:0] in_d  [5];
    logic [63:0] out_d [5];

    assign s_awvalid_i = in_v[0];
    assign {s_awid_i, s_awaddr_i, s_awlen_i, s_awsize_i, s_awburst_i,
            s_awlock_i, s_awcache_i, s_awprot_i} = in_d[0][48:0];
    assign in_r[0]     = s_awready_o;
    assign out_v[0]    = m_awvalid_o;
    assign out_d[0]    = {15'd0, m_awid_o, m_awaddr_o, m_awlen_o, m_awsize_o,
                          m_awburst_o, m_awlock_o, m_awcache_o, m_awprot_o};
    assign m_awready_i = out_r[0];

    assign s_wvalid_i  = in_v[1];
    assign {s_wdata_i, s_wstrb_i, s_wlast_i} = in_d[1][36:0];
    assign in_r[1]     = s_wready_o;
    assign out_v[1]    = m_wvalid_o;
    assign out_d[1]    = {27'd0, m_wdata_o, m_wstrb_o, m_wlast_o};
    assign m_wready_i  = out_r[1];

    assign s_arvalid_i = in_v[2];
    assign {s_arid_i, s_araddr_i, s_arlen_i, s_arsize_i, s_arburst_i,
            s_arlock_i, s_arcache_i, s_arprot_i} = in_d[2][48:0];
    assign in_r[2]     = s_arready_o;
    assign out_v[2]    = m_arvalid_o;
    assign out_d[2]    = {15'd0, m_arid_o, m_araddr_o, m_arlen_o, m_arsize_o,
                          m_arburst_o, m_arlock_o, m_arcache_o, m_arprot_o};
    assign m_arready_i = out_r[2];

    assign m_bvalid_i  = in_v[3];
    assign {m_bid_i, m_bresp_i} = in_d[3][9:0];
    assign in_r[3]     = m_bready_o;
    assign out_v[3]    = s_bvalid_o;
    assign out_d[3]    = {54'd0, s_bid_o, s_bresp_o};
    assign s_bready_i  = out_r[3];

    assign m_rvalid_i  = in_v[4];
    assign {m_rid_i, m_rdata_i, m_rresp_i, m_rlast_i} = in_d[4][42:0];
    assign in_r[4]     = m_rready_o;
    assign out_v[4]    = s_rvalid_o;
    assign out_d[4]    = {21'd0, s_rid_o, s_rdata_o, s_rresp_o, s_rlast_o};
    assign s_rready_i  = out_r[4];

    axi_reg_slice dut (
        .clk(clk), .areset_n(areset_n),
        .s_awid_i(s_awid_i), .s_awaddr_i(s_awaddr_i), .s_awlen_i(s_awlen_i),
        .s_awsize_i(s_awsize_i), .s_awburst_i(s_awburst_i), .s_awlock_i(s_awlock_i),
        .s_awcache_i(s_awcache_i), .s_awprot_i(s_awprot_i),
        .s_awvalid_i(s_awvalid_i), .s_awready_o(s_awready_o),
        .s_wdata_i(s_wdata_i), .s_wstrb_i(s_wstrb_i), .s_wlast_i(s_wlast_i),
        .s_wvalid_i(s_wvalid_i), .s_wready_o(s_wready_o),
        .s_bid_o(s_bid_o), .s_bresp_o(s_bresp_o), .s_bvalid_o(s_bvalid_o), .s_bready_i(s_bready_i),
        .s_arid_i(s_arid_i), .s_araddr_i(s_araddr_i), .s_arlen_i(s_arlen_i),
        .s_arsize_i(s_arsize_i), .s_arburst_i(s_arburst_i), .s_arlock_i(s_arlock_i),
        .s_arcache_i(s_arcache_i), .s_arprot_i(s_arprot_i),
        .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o),
        .s_rid_o(s_rid_o), .s_rdata_o(s_rdata_o), .s_rresp_o(s_rresp_o),
        .s_rlast_o(s_rlast_o), .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i),
        .m_awid_o(m_awid_o), .m_awaddr_o(m_awaddr_o), .m_awlen_o(m_awlen_o),
        .m_awsize_o(m_awsize_o), .m_awburst_o(m_awburst_o), .m_awlock_o(m_awlock_o),
        .m_awcache_o(m_awcache_o), .m_awprot_o(m_awprot_o),
        .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i),
        .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o), .m_wlast_o(m_wlast_o),
        .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i),
        .m_bid_i(m_bid_i), .m_bresp_i(m_bresp_i), .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o),
        .m_arid_o(m_arid_o), .m_araddr_o(m_araddr_o), .m_arlen_o(m_arlen_o),
        .m_arsize_o(m_arsize_o), .m_arburst_o(m_arburst_o), .m_arlock_o(m_arlock_o),
        .m_arcache_o(m_arcache_o), .m_arprot_o(m_arprot_o),
        .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
        .m_rid_i(m_rid_i), .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i),
        .m_rlast_i(m_rlast_i), .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o)
    );

    // scoreboard
    string       ch_name [5] = '{"aw", "w", "ar", "b", "r"};
    int          ch_w    [5] = '{49, 37, 49, 10, 43};
    logic [63:0] ch_mask [5];
    logic [63:0] exp_q   [5][$];
    int          drained [5];
    logic [4:0]  acc_last;
    bit          ready_block;
    int          cyc;
    int          n_vec;
    int          n_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // One cycle: compare outputs to the model, drive new inputs, advance the model.
    task automatic step(input int v_pct, input int r_pct, input bit rst, input bit toggle_r);
        logic [4:0] exp_v, exp_r;
        for (int c = 0; c < 5; c++) begin
            exp_v[c] = (exp_q[c].size() > 0);
            exp_r[c] = !ready_block && (exp_q[c].size() < 2);
            check($sformatf("%s_valid", ch_name[c]), {63'd0, out_v[c]}, {63'd0, exp_v[c]});
            check($sformatf("%s_ready", ch_name[c]), {63'd0, in_r[c]}, {63'd0, exp_r[c]});
            if (exp_v[c])
                check($sformatf("%s_data", ch_name[c]), out_d[c], exp_q[c][0]);
        end

        areset_n = !rst;
        for (int c = 0; c < 5; c++) begin
            if (rst) begin
                in_v[c] = 1'b0;
            end else if (!(in_v[c] && !acc_last[c])) begin
                // A beat offered but not taken stays put, as an AXI source must.
                in_v[c]  = ($urandom_range(0, 99) < v_pct);
                in_d[c]  = {$urandom, $urandom} & ch_mask[c];
            end
            out_r[c] = ($urandom_range(0, 99) < r_pct);
        end
        if (toggle_r) out_r[4] = cyc[0];

        if (rst) begin
            for (int c = 0; c < 5; c++) exp_q[c].delete();
            acc_last    = '0;
            ready_block = 1'b1;
        end else begin
            for (int c = 0; c < 5; c++) begin
                acc_last[c] = in_v[c] && exp_r[c];
                if (exp_v[c] && out_r[c]) begin
                    void'(exp_q[c].pop_front());
                    drained[c]++;
                end
                if (acc_last[c]) exp_q[c].push_back(in_d[c]);
            end
            ready_block = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    function automatic int min_drained();
        int m = drained[0];
        for (int c = 1; c < 5; c++) if (drained[c] < m) m = drained[c];
        return m;
    endfunction

    initial begin
        int budget;
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        for (int c = 0; c < 5; c++) begin
            ch_mask[c] = (64'd1 << ch_w[c]) - 64'd1;
            in_d[c]    = '0;
            drained[c] = 0;
        end
        in_v        = '0;
        out_r       = '0;
        acc_last    = '0;
        ready_block = 1'b1;
        areset_n    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Full throughput on every channel: the skid never fills.
        repeat (40) step(100, 100, 1'b0, 1'b0);

        // R downstream ready toggling: R holds and backpressures upstream.
        repeat (40) step(100, 100, 1'b0, 1'b1);

        // Reset in the middle of traffic, then recovery.
        repeat (5) step(100, 60, 1'b0, 1'b0);
        step(100, 60, 1'b1, 1'b0);
        repeat (20) step(80, 60, 1'b0, 1'b0);

        // Long random run with valid/ready density varied every 64 cycles.
        for (int c = 0; c < 5; c++) drained[c] = 0;
        budget = 0;
        while (min_drained() < 10000 && budget < 60000) begin
            int vp = $urandom_range(40, 100);
            int rp = $urandom_range(40, 100);
            repeat (64) step(vp, rp, 1'b0, 1'b0);
            budget += 64;
        end
        check("beats_done", 64'(min_drained() >= 10000), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
